// File: rtl/axis_mean_square_pkg.sv
// Shared DSP types and format helpers for the mean-square estimator.
package axis_mean_square_pkg;

    localparam int DEF_SAMPLE_WIDTH     = 16;
    localparam int DEF_PARALLEL_SAMPLES = 2;
    localparam int DEF_SAMPLE_FRAC_BITS = 14;
    localparam int DEF_MAX_LOG2_WINDOW  = 8;

    typedef logic signed [DEF_SAMPLE_WIDTH-1:0]   sample_t;
    typedef logic signed [2*DEF_SAMPLE_WIDTH-1:0] product_t;

    // Fractional bits of a squared sample once it is narrowed back to the sample width.
    function automatic int out_frac_bits(input int sample_width, input int frac_bits);
        return sample_width - 2 * (sample_width - frac_bits);
    endfunction

endpackage

// File: rtl/axis_mean_square_if.sv
// Minimal AXI-stream handshake bundle: valid/ready plus a data word.
interface Axis_If #(
    parameter int WIDTH = 16
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_mean_square_acc.sv
// Stage-2 beat summation, windowed accumulation and the registered averaged output.
module axis_mean_square_acc
    import axis_mean_square_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
    parameter int PARALLEL_SAMPLES = DEF_PARALLEL_SAMPLES,
    parameter int MAX_LOG2_WINDOW  = DEF_MAX_LOG2_WINDOW,
    parameter int BASE_SHIFT       = DEF_SAMPLE_WIDTH,
    parameter int WIN_SEL_WIDTH    = $clog2(DEF_MAX_LOG2_WINDOW + 1)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     stall,
    input  logic                                     s1_valid,
    input  logic [2*SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] s1_prod,
    input  logic [WIN_SEL_WIDTH-1:0]                 log2_window,
    output logic                                     out_valid,
    output logic [SAMPLE_WIDTH-1:0]                  out_data
);
    localparam int PROD_W   = 2 * SAMPLE_WIDTH;
    localparam int PAR_LOG2 = $clog2(PARALLEL_SAMPLES);
    localparam int SUM_W    = PROD_W + PAR_LOG2;
    localparam int ACC_W    = SUM_W + MAX_LOG2_WINDOW;
    localparam int CNT_W    = MAX_LOG2_WINDOW;

    logic [SUM_W-1:0]         beat_sum_s;
    logic [ACC_W-1:0]         total_s;
    logic [ACC_W-1:0]         acc_r;
    logic [CNT_W-1:0]         count_r;
    logic [CNT_W-1:0]         last_count_s;
    logic [WIN_SEL_WIDTH-1:0] win_l_r;
    logic [WIN_SEL_WIDTH-1:0] win_req_s;
    logic [WIN_SEL_WIDTH-1:0] win_cur_s;
    logic                     is_last_s;
    logic [SAMPLE_WIDTH-1:0]  result_s;
    logic                     out_valid_r;
    logic [SAMPLE_WIDTH-1:0]  out_data_r;

    // Beat sum, effective window length and the averaged result for a closing window.
    always_comb begin
        beat_sum_s = '0;
        for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
            beat_sum_s = beat_sum_s + SUM_W'(s1_prod[i*PROD_W +: PROD_W]);
        end
        if (log2_window > WIN_SEL_WIDTH'(MAX_LOG2_WINDOW)) begin
            win_req_s = WIN_SEL_WIDTH'(MAX_LOG2_WINDOW);
        end else begin
            win_req_s = log2_window;
        end
        // The first beat of a window uses the live select; later beats use the latched one.
        if (count_r == '0) begin
            win_cur_s = win_req_s;
        end else begin
            win_cur_s = win_l_r;
        end
        last_count_s = CNT_W'((33'd1 << win_cur_s) - 33'd1);
        is_last_s    = (count_r == last_count_s);
        total_s      = acc_r + ACC_W'(beat_sum_s);
        result_s     = SAMPLE_WIDTH'(total_s >> (BASE_SHIFT + PAR_LOG2 + int'(win_cur_s)));
    end

    // Accumulator, beat counter, window latch and output register; all hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r       <= '0;
            count_r     <= '0;
            win_l_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (!stall) begin
            out_valid_r <= s1_valid && is_last_s;
            if (s1_valid) begin
                if (count_r == '0) begin
                    win_l_r <= win_req_s;
                end
                if (is_last_s) begin
                    out_data_r <= result_s;
                    acc_r      <= '0;
                    count_r    <= '0;
                end else begin
                    acc_r      <= total_s;
                    count_r    <= count_r + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: rtl/axis_mean_square.sv
// AXI-stream mean-square estimator: squares each sample, then averages over 2^log2_window beats.
module axis_mean_square
    import axis_mean_square_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
    parameter int PARALLEL_SAMPLES = DEF_PARALLEL_SAMPLES,
    parameter int SAMPLE_FRAC_BITS = DEF_SAMPLE_FRAC_BITS,
    parameter int MAX_LOG2_WINDOW  = DEF_MAX_LOG2_WINDOW,
    parameter int WIN_SEL_WIDTH    = $clog2(MAX_LOG2_WINDOW + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIN_SEL_WIDTH-1:0] log2_window,
    Axis_If.slave                    data_in,
    Axis_If.master                   data_out
);
    localparam int PROD_W = 2 * SAMPLE_WIDTH;
    // Shift that maps the squared format (2F fractional bits) onto the output format.
    localparam int BASE_SHIFT = 2 * SAMPLE_FRAC_BITS - out_frac_bits(SAMPLE_WIDTH, SAMPLE_FRAC_BITS);

    logic                               stall_s;
    logic                               in_ok_s;
    logic [PROD_W*PARALLEL_SAMPLES-1:0] prod_s;
    logic [PROD_W*PARALLEL_SAMPLES-1:0] s1_prod_r;
    logic                               s1_valid_r;
    logic                               out_valid_s;
    logic [SAMPLE_WIDTH-1:0]            out_data_s;

    function automatic logic [PROD_W-1:0] square(input logic signed [SAMPLE_WIDTH-1:0] x);
        logic signed [PROD_W-1:0] xe;
        xe = PROD_W'(x);
        return xe * xe;
    endfunction

    assign stall_s       = out_valid_s && !data_out.ready;
    assign data_in.ready = !reset && !stall_s;
    assign in_ok_s       = data_in.valid && data_in.ready;

    // Full-precision square of every sample in the incoming beat.
    always_comb begin
        prod_s = '0;
        for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
            prod_s[i*PROD_W +: PROD_W] = square(data_in.data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        end
    end

    // Stage-1 product register with its valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_prod_r  <= '0;
        end else if (!stall_s) begin
            s1_valid_r <= in_ok_s;
            if (in_ok_s) begin
                s1_prod_r <= prod_s;
            end
        end
    end

    axis_mean_square_acc #(
        .SAMPLE_WIDTH     (SAMPLE_WIDTH),
        .PARALLEL_SAMPLES (PARALLEL_SAMPLES),
        .MAX_LOG2_WINDOW  (MAX_LOG2_WINDOW),
        .BASE_SHIFT       (BASE_SHIFT),
        .WIN_SEL_WIDTH    (WIN_SEL_WIDTH)
    ) u_acc (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall_s),
        .s1_valid    (s1_valid_r),
        .s1_prod     (s1_prod_r),
        .log2_window (log2_window),
        .out_valid   (out_valid_s),
        .out_data    (out_data_s)
    );

    assign data_out.valid = out_valid_s;
    assign data_out.data  = out_data_s;

endmodule

// File: tb/tb_axis_mean_square.sv
// Self-checking bench for axis_mean_square: directed vectors plus a windowed-average reference model.
module tb_axis_mean_square;
    import axis_mean_square_pkg::*;

    localparam int SW   = 16;
    localparam int P    = 2;
    localparam int F    = 14;
    localparam int MAXW = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] log2_window = 4'd0;

    Axis_If #(.WIDTH(SW*P)) in_if ();
    Axis_If #(.WIDTH(SW))   out_if ();

    axis_mean_square #(
        .SAMPLE_WIDTH     (SW),
        .PARALLEL_SAMPLES (P),
        .SAMPLE_FRAC_BITS (F),
        .MAX_LOG2_WINDOW  (MAXW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .log2_window (log2_window),
        .data_in     (in_if),
        .data_out    (out_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: accepted beats feed a window of squares; results queue in order.
    longint         m_sum = 0;
    int             m_cnt = 0;
    int             m_win = 0;
    int             beats_acc = 0;
    longint         exp_q[$];
    real            rm_q[$];
    logic [SW-1:0]  got_q[$];
    bit             prev_stall = 1'b0;
    logic [SW-1:0]  prev_data;
    sample_t        mx0, mx1;
    longint         mden, mexp;
    real            mreal;

    always @(negedge clk) begin
        if (reset) begin
            m_sum = 0;
            m_cnt = 0;
            exp_q.delete();
            rm_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (in_if.valid && in_if.ready) begin
                beats_acc++;
                mx0 = sample_t'(in_if.data[SW-1:0]);
                mx1 = sample_t'(in_if.data[2*SW-1:SW]);
                if (m_cnt == 0) m_win = (int'(log2_window) > MAXW) ? MAXW : int'(log2_window);
                m_sum += longint'(mx0) * longint'(mx0) + longint'(mx1) * longint'(mx1);
                m_cnt++;
                if (m_cnt == (1 << m_win)) begin
                    mden = longint'(P) << (m_win + 2 * F);
                    exp_q.push_back((m_sum << out_frac_bits(SW, F)) / mden);
                    rm_q.push_back(real'(m_sum) / real'(mden) * (2.0 ** out_frac_bits(SW, F)));
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            if (out_if.valid && out_if.ready) begin
                got_q.push_back(out_if.data);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got 0x%0h with no result due", out_if.data);
                end else begin
                    mexp  = exp_q.pop_front();
                    mreal = rm_q.pop_front();
                    check("model_value", 64'(out_if.data), 64'(mexp));
                    check("within_1lsb", 64'(real'(out_if.data) <= mreal && mreal - real'(out_if.data) < 1.0), 64'd1);
                end
            end
            if (prev_stall) check("stall_data_hold", 64'(out_if.data), 64'(prev_data));
            if (out_if.valid && !out_if.ready) check("stall_in_ready", 64'(in_if.ready), 64'd0);
            prev_stall = out_if.valid && !out_if.ready;
            prev_data  = out_if.data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [SW-1:0] a, input logic [SW-1:0] b);
        int n = 0;
        bit acc = 1'b0;
        in_if.data  = {b, a};
        in_if.valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_if.ready;
            tick();
            n++;
        end while (!acc && n < 200);
        in_if.valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: beat 0x%0h not accepted within 200 cycles", {b, a});
        end
    endtask

    task automatic beat_expect(input logic [SW-1:0] a, input logic [SW-1:0] b,
                               input logic [SW-1:0] exp, input string name);
        send_beat(a, b);
        @(negedge clk);
        check({name, "_lat1"}, 64'(out_if.valid), 64'd0);
        @(negedge clk);
        check({name, "_lat2"}, 64'(out_if.valid), 64'd1);
        check(name, 64'(out_if.data), 64'(exp));
        tick();
    endtask

    initial begin
        int n0;
        int b0;
        bit acc;
        int n;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_in_ready", 64'(in_if.ready), 64'd0);
        check("reset_out_valid", 64'(out_if.valid), 64'd0);
        check("reset_out_data", 64'(out_if.data), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // One-beat window reproduces x^2.
        log2_window = 4'd0;
        beat_expect(16'h4000, 16'h4000, 16'h1000, "w0_one");
        beat_expect(16'hC000, 16'hC000, 16'h1000, "w0_neg_one");
        beat_expect(16'h4000, 16'h0000, 16'h0800, "w0_half");
        beat_expect(16'h8000, 16'h8000, 16'h4000, "w0_most_neg");

        // Four-beat window: nothing until the fourth beat.
        log2_window = 4'd2;
        for (int i = 0; i < 3; i++) begin
            send_beat(16'h2000, 16'h2000);
            repeat (3) begin
                @(negedge clk);
                check("w4_early", 64'(out_if.valid), 64'd0);
            end
            tick();
        end
        beat_expect(16'h2000, 16'h2000, 16'h0400, "w4_value");

        // Output back-pressure: data holds, input blocked, order preserved.
        log2_window  = 4'd0;
        out_if.ready = 1'b0;
        n0 = got_q.size();
        send_beat(16'h4000, 16'h4000);
        send_beat(16'h2000, 16'h2000);
        in_if.data  = {16'h0000, 16'h4000};
        in_if.valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(out_if.valid), 64'd1);
            check("stall_data", 64'(out_if.data), 64'h1000);
            check("stall_ready_low", 64'(in_if.ready), 64'd0);
        end
        tick();
        out_if.ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_if.ready;
            tick();
            n++;
        end while (!acc && n < 50);
        in_if.valid = 1'b0;
        check("stall_resume_accept", 64'(acc), 64'd1);
        repeat (6) tick();
        check("stall_count", 64'(got_q.size() - n0), 64'd3);
        check("stall_order0", 64'(got_q[n0]), 64'h1000);
        check("stall_order1", 64'(got_q[n0+1]), 64'h0400);
        check("stall_order2", 64'(got_q[n0+2]), 64'h0800);

        // Window select changed mid-window applies to the next window only.
        log2_window = 4'd1;
        n0 = got_q.size();
        send_beat(16'h4000, 16'h4000);
        repeat (2) tick();
        log2_window = 4'd3;
        send_beat(16'h4000, 16'h4000);
        repeat (4) tick();
        check("wchg_first_count", 64'(got_q.size() - n0), 64'd1);
        check("wchg_first_value", 64'(got_q[n0]), 64'h1000);
        for (int i = 0; i < 7; i++) send_beat((i < 4) ? 16'h4000 : 16'h0000, (i < 4) ? 16'h4000 : 16'h0000);
        repeat (4) tick();
        check("wchg_no_early", 64'(got_q.size() - n0), 64'd1);
        send_beat(16'h0000, 16'h0000);
        repeat (4) tick();
        check("wchg_second_count", 64'(got_q.size() - n0), 64'd2);
        check("wchg_second_value", 64'(got_q[n0+1]), 64'h0800);

        // Reset three beats into a window discards the partial sum.
        log2_window = 4'd2;
        for (int i = 0; i < 3; i++) send_beat(16'h4000, 16'h4000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n0 = got_q.size();
        for (int i = 0; i < 4; i++) send_beat(16'h2000, 16'h2000);
        repeat (4) tick();
        check("rst_count", 64'(got_q.size() - n0), 64'd1);
        check("rst_value", 64'(got_q[n0]), 64'h0400);

        // Random valid/ready with an eight-beat window.
        log2_window = 4'd3;
        n0 = got_q.size();
        b0 = beats_acc;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            acc = in_if.valid && in_if.ready;
            tick();
            if (acc || !in_if.valid) begin
                in_if.valid = 1'($urandom_range(0, 1));
                in_if.data  = $urandom();
            end
            out_if.ready = ($urandom_range(0, 3) != 0);
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        repeat (10) tick();
        check("rand_out_count", 64'(got_q.size() - n0), 64'((beats_acc - b0) / 8));

        check("model_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_mean_square.md
Name: axis_mean_square

Overview:
AXI-stream mean-square (power) estimator. It is the windowed successor to the per-sample x^2 squarer.
- Squares every signed fixed-point sample in each PARALLEL_SAMPLES-wide beat.
- Sums the squares across the beat and across a runtime-selectable window of 2^log2_window beats.
- Emits one averaged power sample per window.
- Sits after the ADC/DSP sample path and feeds power monitors and triggers.

Parameters:
SAMPLE_WIDTH, 16, bits per input sample and per output sample (signed two's complement)
PARALLEL_SAMPLES, 2, samples per input beat; must be a power of two
SAMPLE_FRAC_BITS, 14, fractional bits of the input format
MAX_LOG2_WINDOW, 8, largest supported log2 of the window length in beats

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
log2_window  input  $clog2(MAX_LOG2_WINDOW+1)  window length select: 2^log2_window beats
data_in  Axis_If slave  SAMPLE_WIDTH*PARALLEL_SAMPLES  packed samples; sample i is at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
data_out  Axis_If master  SAMPLE_WIDTH  one mean-square sample per window

Behaviour:
- Interface decision (fixed): reset is reset, synchronous, active-high; clock is clk.
- Beat transfer: a beat transfers when ok = valid && ready.
- Reset values: data_out.valid=0, data_out.data=0, data_in.ready=0 while reset is asserted. Accumulator, beat counter, pipeline valids and the latched window all clear to 0.
- Stall: stall = data_out.valid && !data_out.ready.
  - data_in.ready = !reset && !stall.
  - While stalled, every pipeline register holds its value.
  - data_out.data is stable while valid and not ready.
- Stage 1 (on data_in.ok): register the full-precision signed product p_i = x_i*x_i, 2*SAMPLE_WIDTH bits, with 2*SAMPLE_FRAC_BITS fractional bits. Register s1_valid alongside.
- Stage 2 (on s1_valid && !stall):
  - beat_sum = sum of the p_i.
  - acc width = 2*SAMPLE_WIDTH + log2(PARALLEL_SAMPLES) + MAX_LOG2_WINDOW; it cannot overflow.
- Window latch:
  - win_l is captured from log2_window when the first beat of a window enters stage 2 (counter == 0).
  - Values above MAX_LOG2_WINDOW clamp to MAX_LOG2_WINDOW.
  - Changes to log2_window mid-window take effect at the next window only.
- End of window (counter == 2^win_l - 1):
  - data_out.data <= (acc + beat_sum) >> (SAMPLE_WIDTH + log2(PARALLEL_SAMPLES) + win_l), floor-truncated to SAMPLE_WIDTH bits.
  - data_out.valid <= 1.
  - acc <= 0, counter <= 0.
- Not end of window: acc += beat_sum, counter += 1.
- Output format: SAMPLE_WIDTH - 2*(SAMPLE_WIDTH - SAMPLE_FRAC_BITS) fractional bits (12 at defaults). This matches the x^2 block, so a 1-beat window with equal samples reproduces x^2.
- data_out.valid clears on data_out.ok unless a new result loads in the same cycle.
- Latency: the last beat of a window is accepted at cycle t; data_out.valid is asserted at t+2 when there is no stall.
- win_l = 0 gives one output per input beat, so full throughput is maintained with ready held at 1.
- Reset mid-window discards the partial sum; the next window starts fresh.
- The most negative input (-2^(SAMPLE_WIDTH-1)) squares correctly without saturation.

Decomposition:
- Shared DSP package holds:
  - the sample typedef (signed SAMPLE_WIDTH);
  - the product typedef (signed 2*SAMPLE_WIDTH);
  - the function deriving output fractional bits.
- Sub-module axis_mean_square_acc: stage-2 accumulator, beat counter, window latch and shift/truncate. The top holds the squaring stage and the handshake/stall logic.

Test Plan:
Defaults W=16, F=14, P=2 for all cases.
- log2_window=0, beat {0x4000,0x4000} (1.0, 1.0) -> one output 0x1000, 2 cycles after accept; {0xC000,0xC000} -> 0x1000.
- log2_window=0, {0x4000,0x0000} -> 0x0800; {0x8000,0x8000} (-2.0) -> 0x4000, no overflow.
- log2_window=2, four beats {0x2000,0x2000} -> exactly one output 0x0400 after the 4th beat; none earlier.
- Random valid and ready, 2000 cycles, log2_window=3 -> output count = floor(beats/8); each value within 1 LSB of the real-valued mean of x^2*2^12. Randomised case, not a fixed-value directed one.
- Output valid with ready held low 5 cycles -> data_out.data stable, data_in.ready=0, no input beat lost; results resume in order.
- log2_window changed 1->3 after the first beat of a window -> that window closes after 2 beats, the next after 8.
- 3 beats into a log2_window=2 window, reset for 1 cycle, then four {0x2000,0x2000} beats -> single output 0x0400.
